// File: rtl/i2s_rx_unit.sv
// I2S receiver: oversamples sck/ws/sd in the clk domain and
// recovers left-justified 24-bit stereo frames as parallel words.
module i2s_rx_unit #(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_in,
    input  logic                  sck_in,
    input  logic                  ws_in,
    input  logic                  sdi_in,
    output logic [DATA_WIDTH-1:0] audio0_out,
    output logic [DATA_WIDTH-1:0] audio1_out,
    output logic                  valid_out,
    output logic                  active_out,
    output logic                  err_out
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sck_d;
    logic                   ws_prev;
    logic                   sck_s;
    logic                   ws_s;
    logic                   sd_s;
    logic                   rise;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ws_s  = ws_sync[SYNC_STAGES-1];
    assign sd_s  = sd_sync[SYNC_STAGES-1];
    assign rise  = sck_s & ~sck_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_d    <= 1'b0;
            ws_prev  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_in};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sdi_in};
            sck_d    <= sck_s;
            // ws history advances on every bit so a re-enable can see the next 1->0 edge
            if (rise) begin
                ws_prev <= ws_s;
            end
        end
    end

    state_t                state;
    state_t                state_n;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_n;
    logic [DATA_WIDTH-1:0] left_sr;
    logic [DATA_WIDTH-1:0] left_n;
    logic [DATA_WIDTH-1:0] right_sr;
    logic [DATA_WIDTH-1:0] right_n;
    logic [DATA_WIDTH-1:0] audio0_n;
    logic [DATA_WIDTH-1:0] audio1_n;
    logic                  valid_n;
    logic                  active_n;
    logic                  err_n;
    logic [DATA_WIDTH-1:0] msb_word;
    logic [DATA_WIDTH-1:0] left_shift;
    logic [DATA_WIDTH-1:0] right_shift;

    assign msb_word    = {{(DATA_WIDTH-1){1'b0}}, sd_s};
    assign left_shift  = {left_sr[DATA_WIDTH-2:0], sd_s};
    assign right_shift = {right_sr[DATA_WIDTH-2:0], sd_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            left_sr    <= '0;
            right_sr   <= '0;
            audio0_out <= '0;
            audio1_out <= '0;
            valid_out  <= 1'b0;
            active_out <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            left_sr    <= left_n;
            right_sr   <= right_n;
            audio0_out <= audio0_n;
            audio1_out <= audio1_n;
            valid_out  <= valid_n;
            active_out <= active_n;
            err_out    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        left_n   = left_sr;
        right_n  = right_sr;
        audio0_n = audio0_out;
        audio1_n = audio1_out;
        valid_n  = 1'b0;
        active_n = active_out;
        err_n    = 1'b0;

        if (!enable_in) begin
            state_n  = IDLE;
            cnt_n    = '0;
            active_n = 1'b0;
        end else if (rise) begin
            unique case (state)
                IDLE: begin
                    if (ws_prev && !ws_s) begin
                        left_n  = msb_word;
                        cnt_n   = ONE;
                        state_n = LEFT;
                    end
                end
                LEFT: begin
                    if (!ws_s && cnt < FULL) begin
                        left_n = left_shift;
                        cnt_n  = cnt + ONE;
                    end else if (ws_s && cnt == FULL) begin
                        right_n = msb_word;
                        cnt_n   = ONE;
                        state_n = RIGHT;
                    end else begin
                        err_n    = 1'b1;
                        active_n = 1'b0;
                        cnt_n    = '0;
                        state_n  = IDLE;
                    end
                end
                RIGHT: begin
                    if (!ws_s) begin
                        // ws fall always starts a new frame; a short right slot is dropped
                        left_n  = msb_word;
                        cnt_n   = ONE;
                        state_n = LEFT;
                        if (cnt < FULL) begin
                            err_n    = 1'b1;
                            active_n = 1'b0;
                        end
                    end else if (cnt < FULL) begin
                        right_n = right_shift;
                        cnt_n   = cnt + ONE;
                        if (cnt == LAST) begin
                            audio0_n = left_sr;
                            audio1_n = right_shift;
                            valid_n  = 1'b1;
                            active_n = 1'b1;
                        end
                    end else begin
                        err_n    = 1'b1;
                        active_n = 1'b0;
                        cnt_n    = '0;
                        state_n  = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_rx_unit.sv
// Directed bench for i2s_rx_unit: drives I2S frames and checks
// strobes, values, latency and framing-error handling.
module tb_i2s_rx_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable_in = 1'b0;
    logic        sck_in = 1'b0;
    logic        ws_in = 1'b0;
    logic        sdi_in = 1'b0;
    logic [23:0] audio0_out;
    logic [23:0] audio1_out;
    logic        valid_out;
    logic        active_out;
    logic        err_out;

    i2s_rx_unit #(.DATA_WIDTH(24), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .enable_in(enable_in),
        .sck_in(sck_in),
        .ws_in(ws_in),
        .sdi_in(sdi_in),
        .audio0_out(audio0_out),
        .audio1_out(audio1_out),
        .valid_out(valid_out),
        .active_out(active_out),
        .err_out(err_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int hi = 4;
    int lo = 4;
    int n_val = 0;
    int n_err = 0;
    int n_ovl = 0;
    int n_long = 0;
    int n_unexp = 0;
    logic pv = 1'b0;
    logic pe = 1'b0;
    logic [23:0] q0[$];
    logic [23:0] q1[$];
    logic [23:0] last0 = '0;
    logic [23:0] last1 = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [23:0] e0;
        logic [23:0] e1;
        if (valid_out && err_out) n_ovl++;
        if ((valid_out && pv) || (err_out && pe)) n_long++;
        pv = valid_out;
        pe = err_out;
        if (err_out) n_err++;
        if (valid_out) begin
            n_val++;
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("audio0", {8'h0, audio0_out}, {8'h0, e0});
                chk("audio1", {8'h0, audio1_out}, {8'h0, e1});
                chk("latency", cyc - rise_cyc, 3);
            end else begin
                n_unexp++;
            end
        end
    end

    task automatic send_bit(input logic w, input logic d);
        sck_in = 1'b0;
        ws_in  = w;
        sdi_in = d;
        repeat (lo) @(negedge clk);
        sck_in   = 1'b1;
        rise_cyc = cyc;
        repeat (hi) @(negedge clk);
    endtask

    task automatic send_slot(input logic w, input logic [23:0] v,
                             input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            if (i < 24) b = v[23-i];
            else b = 1'b0;
            send_bit(w, b);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                              input int nl, input int nr);
        send_slot(1'b0, l, nl);
        send_slot(1'b1, r, nr);
    endtask

    task automatic good_frame(input logic [23:0] l, input logic [23:0] r);
        q0.push_back(l);
        q1.push_back(r);
        last0 = l;
        last1 = r;
        send_frame(l, r, 24, 24);
    endtask

    initial begin
        int v0;
        int e0;
        logic [23:0] rl;
        logic [23:0] rr;

        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_a0", {8'h0, audio0_out}, 32'h0);
        chk("rst_a1", {8'h0, audio1_out}, 32'h0);
        chk("rst_active", {31'h0, active_out}, 32'h0);
        chk("rst_valid_cnt", n_val, 0);
        chk("rst_err_cnt", n_err, 0);

        enable_in = 1'b1;
        send_slot(1'b1, 24'h0, 2);
        good_frame(24'hABCDEF, 24'h123456);
        repeat (6) @(negedge clk);
        chk("nom1_valid_cnt", n_val, 1);
        chk("nom1_active", {31'h0, active_out}, 32'h1);
        good_frame(24'h800001, 24'h7FFFFE);
        repeat (6) @(negedge clk);
        chk("nom2_valid_cnt", n_val, 2);
        chk("nom_err_cnt", n_err, 0);

        hi = 2;
        lo = 2;
        v0 = n_val;
        for (int k = 0; k < 4; k++) begin
            rl = 24'($urandom);
            rr = 24'($urandom);
            good_frame(rl, rr);
        end
        repeat (6) @(negedge clk);
        chk("fast_valid_cnt", n_val - v0, 4);
        chk("fast_err_cnt", n_err, 0);

        hi = 4;
        lo = 4;
        v0 = n_val;
        e0 = n_err;
        send_frame(24'h5A5A5A, 24'hA5A5A5, 23, 24);
        chk("sl_err_cnt", n_err - e0, 1);
        chk("sl_active", {31'h0, active_out}, 32'h0);
        chk("sl_valid_cnt", n_val - v0, 0);
        good_frame(24'h000001, 24'hFFFFFF);
        repeat (6) @(negedge clk);
        chk("sl_resync_cnt", n_val - v0, 1);

        v0 = n_val;
        e0 = n_err;
        send_frame(24'h111111, 24'h222222, 24, 23);
        good_frame(24'hC0FFEE, 24'h00BEEF);
        repeat (6) @(negedge clk);
        chk("sr_err_cnt", n_err - e0, 1);
        chk("sr_valid_cnt", n_val - v0, 1);

        v0 = n_val;
        e0 = n_err;
        send_frame(24'h333333, 24'h444444, 25, 24);
        chk("ll_err_cnt", n_err - e0, 1);
        chk("ll_active", {31'h0, active_out}, 32'h0);
        good_frame(24'h13579B, 24'h2468AC);
        repeat (6) @(negedge clk);
        chk("ll_valid_cnt", n_val - v0, 1);

        v0 = n_val;
        e0 = n_err;
        send_slot(1'b0, 24'h666666, 24);
        send_slot(1'b1, 24'h777777, 12);
        enable_in = 1'b0;
        send_slot(1'b1, 24'h777000, 12);
        repeat (6) @(negedge clk);
        chk("en_valid_cnt", n_val - v0, 0);
        chk("en_err_cnt", n_err - e0, 0);
        chk("en_active", {31'h0, active_out}, 32'h0);
        chk("en_hold_a0", {8'h0, audio0_out}, {8'h0, last0});
        chk("en_hold_a1", {8'h0, audio1_out}, {8'h0, last1});
        enable_in = 1'b1;
        send_slot(1'b1, 24'h0, 2);
        good_frame(24'hFEDCBA, 24'h654321);
        repeat (6) @(negedge clk);
        chk("en_resync_cnt", n_val - v0, 1);

        v0 = n_val;
        send_slot(1'b0, 24'h999999, 24);
        send_slot(1'b1, 24'h888888, 10);
        rst = 1'b1;
        #1;
        chk("mrst_a0", {8'h0, audio0_out}, 32'h0);
        chk("mrst_a1", {8'h0, audio1_out}, 32'h0);
        chk("mrst_active", {31'h0, active_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_slot(1'b1, 24'h888000, 14);
        good_frame(24'h0F0F0F, 24'hF0F0F0);
        repeat (6) @(negedge clk);
        chk("mrst_valid_cnt", n_val - v0, 1);

        chk("queue_left", q0.size(), 0);
        chk("unexpected_valid", n_unexp, 0);
        chk("strobe_overlap", n_ovl, 0);
        chk("strobe_width", n_long, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
